// File: rtl/video_frame_meter.sv
// -----------------------------------------------------------------------------
// video_frame_meter
//
// Measures the active raster of the core's video stream and derives a
// vertically cropped display-enable from the measured geometry. The measured
// active height drives the crop window, so the window follows the core if it
// changes its line count.
//
// Ports
//   CLK_VIDEO   video clock
//   reset       synchronous, active-high
//   ce_pix      pixel clock enable; video inputs are sampled only when high
//   de_in       active display
//   hs_in       horizontal sync (active-high)
//   vs_in       vertical sync (active-high)
//   crop_size   requested visible lines, 0 disables the crop
//   crop_off    signed crop window offset in lines (-16..+15)
//   act_width   maximum active pixels per line over the last frame
//   act_height  active lines in the last frame
//   line_total  HS pulses in the last frame
//   valid       geometry identical over the last two latched frames
//   frame_stb   one-cycle pulse when new measurements are latched
//   de_out      cropped display-enable, one clock behind de_in
// -----------------------------------------------------------------------------
module video_frame_meter #(
    parameter int MAXCNT = 4095
) (
    input  logic        CLK_VIDEO,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic        de_in,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic [9:0]  crop_size,
    input  logic [4:0]  crop_off,
    output logic [11:0] act_width,
    output logic [11:0] act_height,
    output logic [11:0] line_total,
    output logic        valid,
    output logic        frame_stb,
    output logic        de_out
);

    localparam logic [11:0] SAT = 12'(MAXCNT);

    logic        de_q, hs_q, vs_q;
    logic        de_fall, hs_rise, vs_rise;
    logic [11:0] hcnt, wmax, vline, htot;
    logic [11:0] wmax_nx, vline_nx, htot_nx;
    logic        valid_nx, en_nx;
    logic signed [12:0] h_s, cs_s, diff_s, base_s, off_s, start_s, start_lim;
    logic [12:0] crop_start;
    logic [9:0]  crop_cs;
    logic        crop_en;
    logic        in_window;

    // Counters stop at the saturation value instead of wrapping.
    function automatic logic [11:0] sat_inc(input logic [11:0] x);
        return (x >= SAT) ? x : x + 12'd1;
    endfunction

    // Edges compare the live input against the copy taken on the previous
    // pixel-enable cycle, so they only ever fire on a ce_pix cycle.
    assign de_fall = ce_pix &&  de_q && !de_in;
    assign hs_rise = ce_pix && !hs_q &&  hs_in;
    assign vs_rise = ce_pix && !vs_q &&  vs_in;

    // Next values of the per-frame accumulators. They are also what gets
    // latched at a frame boundary, so a line whose DE falls in the same pixel
    // as the VS rise is already counted in the latched height and width.
    always_comb begin
        wmax_nx  = wmax;
        vline_nx = vline;
        htot_nx  = htot;
        if (de_fall) begin
            wmax_nx  = (hcnt > wmax) ? hcnt : wmax;
            vline_nx = sat_inc(vline);
        end
        if (hs_rise) begin
            htot_nx = sat_inc(htot);
        end
    end

    // Crop window for the frame that starts at this boundary, computed from
    // the height about to be latched. Everything is 13-bit signed so that a
    // crop larger than the picture or a negative offset cannot wrap. The
    // window is centred and then shifted, but never leaves the picture.
    always_comb begin
        h_s    = $signed({1'b0, vline_nx});
        cs_s   = $signed({3'b000, crop_size});
        diff_s = h_s - cs_s;
        base_s = diff_s >>> 1;
        off_s  = $signed({{8{crop_off[4]}}, crop_off});
        start_s = base_s + off_s;
        if (start_s < 13'sd0) begin
            start_lim = 13'sd0;
        end else if (start_s > diff_s) begin
            start_lim = diff_s;
        end else begin
            start_lim = start_s;
        end
        valid_nx = (wmax_nx == act_width) && (vline_nx == act_height);
        en_nx    = (crop_size != 10'd0) && valid_nx && (cs_s < h_s);
    end

    // Input sample registers used for edge detection; frozen while ce_pix is low.
    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            de_q <= 1'b0;
            hs_q <= 1'b0;
            vs_q <= 1'b0;
        end else if (ce_pix) begin
            de_q <= de_in;
            hs_q <= hs_in;
            vs_q <= vs_in;
        end
    end

    // Per-frame accumulators. A VS rise clears them for the new frame; a
    // reset discards whatever partial frame was in progress.
    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            hcnt  <= '0;
            wmax  <= '0;
            vline <= '0;
            htot  <= '0;
        end else if (vs_rise) begin
            hcnt  <= '0;
            wmax  <= '0;
            vline <= '0;
            htot  <= '0;
        end else begin
            wmax  <= wmax_nx;
            vline <= vline_nx;
            htot  <= htot_nx;
            if (de_fall) begin
                hcnt <= '0;
            end else if (ce_pix && de_in) begin
                hcnt <= sat_inc(hcnt);
            end
        end
    end

    // Latched measurements and the crop window registers. Both change on the
    // same clock, so the new window governs the first line of the new frame.
    // crop_size/crop_off are only looked at here, which is why changing them
    // mid-frame has no effect until the next boundary.
    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            act_width  <= '0;
            act_height <= '0;
            line_total <= '0;
            valid      <= 1'b0;
            frame_stb  <= 1'b0;
            crop_start <= '0;
            crop_cs    <= '0;
            crop_en    <= 1'b0;
        end else begin
            frame_stb <= vs_rise;
            if (vs_rise) begin
                act_width  <= wmax_nx;
                act_height <= vline_nx;
                line_total <= htot_nx;
                valid      <= valid_nx;
                crop_start <= start_lim;
                crop_cs    <= crop_size;
                crop_en    <= en_nx;
            end
        end
    end

    // vline is the index of the active line currently being displayed, so the
    // window test is done directly against it. start + size never exceeds the
    // measured height, so the 13-bit sum cannot overflow.
    assign in_window = ({1'b0, vline} >= crop_start) &&
                       ({1'b0, vline} < (crop_start + {3'b000, crop_cs}));

    // Cropped display-enable, registered every clock regardless of ce_pix.
    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            de_out <= 1'b0;
        end else begin
            de_out <= de_in && (!crop_en || in_window);
        end
    end

endmodule

// File: tb/tb_video_frame_meter.sv
// -----------------------------------------------------------------------------
// tb_video_frame_meter
//
// Drives synthetic rasters into video_frame_meter and checks the latched
// geometry, frame strobe and cropped display-enable against a frame-level
// model of the expected picture.
// -----------------------------------------------------------------------------
module tb_video_frame_meter;

    localparam int MAXCNT = 4095;

    logic        CLK_VIDEO = 1'b0;
    logic        reset;
    logic        ce_pix, de_in, hs_in, vs_in;
    logic [9:0]  crop_size;
    logic [4:0]  crop_off;
    logic [11:0] act_width, act_height, line_total;
    logic        valid, frame_stb, de_out;

    video_frame_meter #(.MAXCNT(MAXCNT)) dut (
        .CLK_VIDEO (CLK_VIDEO),
        .reset     (reset),
        .ce_pix    (ce_pix),
        .de_in     (de_in),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .crop_size (crop_size),
        .crop_off  (crop_off),
        .act_width (act_width),
        .act_height(act_height),
        .line_total(line_total),
        .valid     (valid),
        .frame_stb (frame_stb),
        .de_out    (de_out)
    );

    always #5 CLK_VIDEO = ~CLK_VIDEO;

    int errors = 0;
    int checks = 0;

    // Latched picture as the model expects it, plus the crop window in force.
    int m_w = 0, m_h = 0, m_t = 0;
    bit m_valid = 1'b0, m_en = 1'b0;
    int m_start = 0, m_cs = 0;

    // The frame currently being generated.
    int f_wmax = 0, f_lines = 0, f_hs = 0, cur_w = 0;
    bit line_open = 1'b0;

    // Per-frame observation tallies.
    int de_bad = 0, stb_bad = 0, first_line = -1, last_line = -1;

    // Stimulus knobs.
    int cediv = 1;
    bit jitter = 1'b0;
    int next_cs = 0, next_off = 0;
    int width;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clock: drive inputs, step past the edge, compare de_out and frame_stb.
    task automatic applyStimulus(input bit ce, input bit de, input bit hs, input bit vs, input bit boundary);
        bit exp_de;
        ce_pix = ce;
        de_in  = de;
        hs_in  = hs;
        vs_in  = vs;
        exp_de = de && (!m_en || (f_lines >= m_start && f_lines < m_start + m_cs));
        @(posedge CLK_VIDEO);
        #1;
        if (de_out !== exp_de) de_bad++;
        if (frame_stb !== (ce && boundary && !reset)) stb_bad++;
        if (de_out === 1'b1) begin
            if (first_line < 0) first_line = f_lines;
            last_line = f_lines;
        end
    endtask

    // One pixel slot: cediv-1 idle clocks (plus occasional extra), then ce.
    task automatic slot(input bit de, input bit hs, input bit vs, input bit boundary);
        for (int i = 1; i < cediv; i++) applyStimulus(1'b0, de, hs, vs, 1'b0);
        if (jitter && ($urandom_range(0, 7) == 0)) applyStimulus(1'b0, de, hs, vs, 1'b0);
        applyStimulus(1'b1, de, hs, vs, boundary);
    endtask

    task automatic closeLine();
        int w;
        w = (cur_w > MAXCNT) ? MAXCNT : cur_w;
        if (w > f_wmax) f_wmax = w;
        if (f_lines < MAXCNT) f_lines++;
        line_open = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        checkOutput("rst_act_width",  act_width,  16'd0);
        checkOutput("rst_act_height", act_height, 16'd0);
        checkOutput("rst_line_total", line_total, 16'd0);
        checkOutput("rst_valid",      valid,      16'd0);
        checkOutput("rst_frame_stb",  frame_stb,  16'd0);
        checkOutput("rst_de_out",     de_out,     16'd0);
        m_w = 0; m_h = 0; m_t = 0; m_valid = 1'b0; m_en = 1'b0;
        f_wmax = 0; f_lines = 0; f_hs = 0; line_open = 1'b0;
    endtask

    // VS rise: the model closes the pending line, latches the frame and
    // works out the crop window from the rules, then the outputs are compared.
    task automatic frameBoundary();
        int diff, st;
        bit nv;
        slot(1'b0, 1'b0, 1'b1, 1'b1);
        if (line_open) closeLine();
        nv = (f_wmax == m_w) && (f_lines == m_h);
        m_w = f_wmax;
        m_h = f_lines;
        m_t = (f_hs > MAXCNT) ? MAXCNT : f_hs;
        m_valid = nv;
        m_cs = int'(crop_size);
        m_en = (m_cs != 0) && m_valid && (m_cs < m_h);
        diff = m_h - m_cs;
        st = diff / 2 + int'($signed(crop_off));
        if (st < 0) st = 0;
        if (st > diff) st = diff;
        m_start = st;
        checkOutput("frame_stb",  frame_stb,  16'd1);
        checkOutput("act_width",  act_width,  16'(m_w));
        checkOutput("act_height", act_height, 16'(m_h));
        checkOutput("line_total", line_total, 16'(m_t));
        checkOutput("valid",      valid,      16'(m_valid));
        checkOutput("de_out_clocks_wrong", 16'(de_bad), 16'd0);
        checkOutput("frame_stb_clocks_wrong", 16'(stb_bad), 16'd0);
        f_wmax = 0; f_lines = 0; f_hs = 0;
        de_bad = 0; stb_bad = 0;
    endtask

    // One frame of tot lines with h active lines of maximum width w. With
    // tail set, the active lines end the frame and the last DE fall lands on
    // the next VS rise. crop inputs change at line 100 to test they wait.
    task automatic runFrame(input int h, input int tot, input int w, input bit do_boundary,
                            input bit tail, input int reset_line);
        int first_act, wl;
        bit v;
        if (do_boundary) frameBoundary();
        first_line = -1;
        last_line  = -1;
        first_act = tail ? (tot - h) : ((tot - h) / 2);
        for (int l = 0; l < tot; l++) begin
            v = do_boundary && (l < 3);
            if (l == reset_line) doReset();
            if (l == 100) begin
                crop_size = 10'(next_cs);
                crop_off  = 5'(next_off);
            end
            slot(1'b0, 1'b1, v, 1'b0);
            if (f_hs < MAXCNT) f_hs++;
            slot(1'b0, 1'b0, v, 1'b0);
            if (l >= first_act && l < first_act + h) begin
                wl = (l == first_act) ? w : (w - int'($urandom_range(0, 3)));
                for (int p = 0; p < wl; p++) slot(1'b1, 1'b0, v, 1'b0);
                cur_w = wl;
                line_open = 1'b1;
                if (!(tail && l == tot - 1)) begin
                    slot(1'b0, 1'b0, v, 1'b0);
                    closeLine();
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        ce_pix = 1'b0; de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
        crop_size = '0; crop_off = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        doReset();
        width = int'($urandom_range(6, 10));
        $display("[TB] active width this run: %0d", width);

        // Tail of a frame already in progress, then a stable raster.
        runFrame(20, 25, width, 1'b0, 1'b0, -1);
        cediv = 4;
        runFrame(240, 262, width, 1'b1, 1'b0, -1);
        cediv = 2; jitter = 1'b1;
        next_cs = 216; next_off = 0;
        runFrame(240, 262, width, 1'b1, 1'b0, -1);
        checkOutput("stable_width",  act_width,  16'(width));
        checkOutput("stable_height", act_height, 16'd240);
        checkOutput("stable_total",  line_total, 16'd262);
        checkOutput("valid_after_first", valid,  16'd0);

        // Crop variants on the stable 240-line raster.
        cediv = 1;
        next_cs = 216; next_off = -12;
        runFrame(240, 262, width, 1'b1, 1'b0, -1);
        checkOutput("valid_after_second", valid, 16'd1);
        checkOutput("crop0_first", 16'(first_line), 16'd12);
        checkOutput("crop0_last",  16'(last_line),  16'd227);
        next_off = 15;
        runFrame(240, 262, width, 1'b1, 1'b0, -1);
        checkOutput("cropm12_first", 16'(first_line), 16'd0);
        checkOutput("cropm12_last",  16'(last_line),  16'd215);
        next_cs = 300; next_off = 0;
        runFrame(240, 262, width, 1'b1, 1'b0, -1);
        checkOutput("cropp15_first", 16'(first_line), 16'd24);
        checkOutput("cropp15_last",  16'(last_line),  16'd239);
        next_cs = 0;
        runFrame(240, 262, width, 1'b1, 1'b0, -1);
        checkOutput("crop300_first", 16'(first_line), 16'd0);
        checkOutput("crop300_last",  16'(last_line),  16'd239);
        next_cs = 180; next_off = int'($urandom_range(0, 31)) - 16;
        runFrame(240, 262, width, 1'b1, 1'b0, -1);
        checkOutput("crop_off_first", 16'(first_line), 16'd0);
        checkOutput("crop_off_last",  16'(last_line),  16'd239);

        // Height change 240 -> 200, then a frame whose last DE fall meets VS.
        runFrame(200, 262, width, 1'b1, 1'b0, -1);
        runFrame(200, 262, width, 1'b1, 1'b0, -1);
        checkOutput("hchg_valid",  valid,      16'd0);
        checkOutput("hchg_height", act_height, 16'd200);
        checkOutput("hchg_first",  16'(first_line), 16'd0);
        checkOutput("hchg_last",   16'(last_line),  16'd199);
        runFrame(240, 262, width, 1'b1, 1'b1, -1);
        checkOutput("hchg_valid_back", valid, 16'd1);

        // Reset in the middle of the active area.
        runFrame(240, 262, width, 1'b1, 1'b0, 105);
        runFrame(240, 262, width, 1'b1, 1'b0, -1);
        checkOutput("post_rst_valid", valid, 16'd0);
        runFrame(240, 262, width, 1'b1, 1'b0, -1);
        checkOutput("post_rst_valid2", valid, 16'd0);

        // Saturating line width.
        runFrame(1, 4, 5000, 1'b1, 1'b0, -1);
        checkOutput("post_rst_valid3", valid, 16'd1);
        runFrame(3, 6, width, 1'b1, 1'b0, -1);
        checkOutput("sat_width", act_width, 16'd4095);
        frameBoundary();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
